// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray-to-binary tracker.
// The decode helpers work on zero-extended 32-bit vectors and take the live width as an argument.
package gray_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_e;

   localparam logic [7:0] ERR_MAX = 8'hFF;

   // Binary bit i is the XOR of every Gray bit at or above i.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
      logic [31:0] b;
      logic        acc;
      b   = 32'd0;
      acc = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (i < int'(width)) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end else begin
            b[i] = 1'b0;
         end
      end
      return b;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
      logic [31:0] mask;
      mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (b ^ (b >> 1)) & mask;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-stage vector synchroniser for a Gray-coded bus. Safe because a Gray source changes
// at most one bit per update, so any sample is either the old or the new value.
module gray_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [STAGES-1:0][WIDTH-1:0] r_chain;

   // Shift chain: stage 0 samples the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Synchronises a Gray count, decodes it, and classifies each change as +1, -1 or an illegal jump,
// keeping a wrapping signed position and a saturating error count.
module gray_to_binary_tracker
   import gray_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int POS_WIDTH   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH-1:0]            gray_in,
   input  logic                        clr,
   output logic [WIDTH-1:0]            bin_out,
   output logic                        valid,
   output logic                        step_up,
   output logic                        step_dn,
   output logic                        err_jump,
   output logic signed [POS_WIDTH-1:0] position,
   output logic [7:0]                  err_count
);

   // Baseline is taken only once the synchroniser is full of post-reset samples.
   localparam logic [2:0]       WAIT_LAST = 3'(SYNC_STAGES + 1);
   localparam logic [WIDTH-1:0] DELTA_UP  = WIDTH'(1);
   localparam logic [WIDTH-1:0] DELTA_DN  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] DELTA_NO  = {WIDTH{1'b0}};

   state_e                 r_state;
   state_e                 w_state_nxt;
   logic [2:0]             r_wait_cnt;
   logic [2:0]             w_wait_nxt;
   logic [WIDTH-1:0]       w_gray_sync;
   logic [WIDTH-1:0]       w_decode;
   logic [WIDTH-1:0]       w_delta;
   logic                   w_base_done;

   logic [WIDTH-1:0]       r_bin_out;
   logic                   r_valid;
   logic                   r_step_up;
   logic                   r_step_dn;
   logic                   r_err_jump;
   logic [POS_WIDTH-1:0]   r_position;
   logic [7:0]             r_err_count;

   logic [WIDTH-1:0]       w_bin_nxt;
   logic                   w_valid_nxt;
   logic                   w_up;
   logic                   w_dn;
   logic                   w_err;
   logic [POS_WIDTH-1:0]   w_pos_step;
   logic [POS_WIDTH-1:0]   w_pos_nxt;
   logic [7:0]             w_errc_step;
   logic [7:0]             w_errc_nxt;

   gray_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (gray_in),
      .o_sync  (w_gray_sync)
   );

   assign w_decode    = WIDTH'(gray2bin(32'(w_gray_sync), WIDTH));
   assign w_delta     = w_decode - r_bin_out;
   assign w_base_done = (r_wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:  w_state_nxt = w_base_done ? ST_TRACK : ST_INIT;
         ST_TRACK: w_state_nxt = ST_TRACK;
         default:  w_state_nxt = ST_INIT;
      endcase
   end

   // Next values of every registered output; WIDTH = 1 resolves +1/-1 ambiguity as step_up.
   always_comb begin
      w_wait_nxt  = r_wait_cnt;
      w_bin_nxt   = r_bin_out;
      w_valid_nxt = r_valid;
      w_up        = 1'b0;
      w_dn        = 1'b0;
      w_err       = 1'b0;
      w_pos_step  = r_position;
      w_errc_step = r_err_count;
      case (r_state)
         ST_INIT: begin
            if (w_base_done) begin
               w_bin_nxt   = w_decode;
               w_valid_nxt = 1'b1;
            end else begin
               w_wait_nxt = r_wait_cnt + 3'd1;
            end
         end
         ST_TRACK: begin
            w_bin_nxt = w_decode;
            if (w_delta == DELTA_UP) begin
               w_up       = 1'b1;
               w_pos_step = r_position + POS_WIDTH'(1);
            end else if (w_delta == DELTA_DN) begin
               w_dn       = 1'b1;
               w_pos_step = r_position - POS_WIDTH'(1);
            end else if (w_delta != DELTA_NO) begin
               w_err       = 1'b1;
               w_errc_step = (r_err_count == ERR_MAX) ? ERR_MAX : (r_err_count + 8'd1);
            end else begin
               w_pos_step = r_position;
            end
         end
         default: begin
            w_wait_nxt = 3'd0;
         end
      endcase
      w_pos_nxt  = clr ? {POS_WIDTH{1'b0}} : w_pos_step;
      w_errc_nxt = clr ? 8'd0 : w_errc_step;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt  <= 3'd0;
         r_bin_out   <= {WIDTH{1'b0}};
         r_valid     <= 1'b0;
         r_step_up   <= 1'b0;
         r_step_dn   <= 1'b0;
         r_err_jump  <= 1'b0;
         r_position  <= {POS_WIDTH{1'b0}};
         r_err_count <= 8'd0;
      end else begin
         r_wait_cnt  <= w_wait_nxt;
         r_bin_out   <= w_bin_nxt;
         r_valid     <= w_valid_nxt;
         r_step_up   <= w_up;
         r_step_dn   <= w_dn;
         r_err_jump  <= w_err;
         r_position  <= w_pos_nxt;
         r_err_count <= w_errc_nxt;
      end
   end

   assign bin_out   = r_bin_out;
   assign valid     = r_valid;
   assign step_up   = r_step_up;
   assign step_dn   = r_step_dn;
   assign err_jump  = r_err_jump;
   assign position  = r_position;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed bench for gray_to_binary_tracker: an edge-indexed reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_gray_to_binary_tracker;

   localparam int W  = 4;
   localparam int S  = 2;
   localparam int PW = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 clr;
   logic [W-1:0]         gray_in;
   logic [W-1:0]         bin_out;
   logic                 valid;
   logic                 step_up;
   logic                 step_dn;
   logic                 err_jump;
   logic signed [PW-1:0] position;
   logic [7:0]           err_count;

   int total = 0;
   int bad   = 0;
   int up_seen  = 0;
   int dn_seen  = 0;
   int err_seen = 0;

   always #5 clk = ~clk;

   gray_to_binary_tracker #(.WIDTH(W), .SYNC_STAGES(S), .POS_WIDTH(PW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gray_in   (gray_in),
      .clr       (clr),
      .bin_out   (bin_out),
      .valid     (valid),
      .step_up   (step_up),
      .step_dn   (step_dn),
      .err_jump  (err_jump),
      .position  (position),
      .err_count (err_count)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int tb_b2g(input int b);
      return (b ^ (b >> 1)) & 15;
   endfunction

   // Decode by searching for the binary value whose Gray code matches.
   function automatic int tb_g2b(input logic [W-1:0] g);
      for (int b = 0; b < 16; b++) begin
         if (tb_b2g(b) == int'(g)) return b;
      end
      return 0;
   endfunction

   // Reference model: edge n (counted from reset release) sees the input sampled at edge n-S.
   logic [W-1:0]  hist[$];
   int            m_n;
   logic [W-1:0]  m_bin;
   logic          m_valid, m_up, m_dn, m_err;
   logic [PW-1:0] m_pos;
   int            m_errc;

   function automatic int dec_at(input int n);
      return (n > S) ? tb_g2b(hist[n-S-1]) : 0;
   endfunction

   function automatic int delta_at(input int n);
      return ((dec_at(n) - int'(m_bin)) % 16 + 16) % 16;
   endfunction

   function automatic bit is_err(input int d);
      return (d != 0) && (d != 1) && (d != 15);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n <= 0; m_bin <= '0; m_valid <= 1'b0;
         m_up <= 1'b0; m_dn <= 1'b0; m_err <= 1'b0;
         m_pos <= '0; m_errc <= 0;
         hist.delete();
      end else begin
         hist.push_back(gray_in);
         m_n <= m_n + 1;
         m_up <= 1'b0; m_dn <= 1'b0; m_err <= 1'b0;
         if (m_n + 1 == S + 2) begin
            m_bin   <= 4'(dec_at(m_n + 1));
            m_valid <= 1'b1;
         end else if (m_n + 1 > S + 2) begin
            m_bin  <= 4'(dec_at(m_n + 1));
            m_up   <= (delta_at(m_n + 1) == 1);
            m_dn   <= (delta_at(m_n + 1) == 15);
            m_err  <= is_err(delta_at(m_n + 1));
            m_pos  <= clr ? 16'd0 :
                      (delta_at(m_n + 1) == 1)  ? m_pos + 16'd1 :
                      (delta_at(m_n + 1) == 15) ? m_pos - 16'd1 : m_pos;
            m_errc <= clr ? 0 :
                      (is_err(delta_at(m_n + 1)) && m_errc < 255) ? m_errc + 1 : m_errc;
         end else begin
            m_pos  <= 16'd0;
            m_errc <= 0;
         end
      end
   end

   always @(negedge clk) begin
      check("bin_out",   int'(bin_out),   int'(m_bin));
      check("valid",     int'(valid),     int'(m_valid));
      check("step_up",   int'(step_up),   int'(m_up));
      check("step_dn",   int'(step_dn),   int'(m_dn));
      check("err_jump",  int'(err_jump),  int'(m_err));
      check("position",  int'($unsigned(position)), int'(m_pos));
      check("err_count", int'(err_count), m_errc);
      check("one_hot",   int'(step_up) + int'(step_dn) + int'(err_jump) <= 1 ? 1 : 0, 1);
      if (step_up)  up_seen  <= up_seen + 1;
      if (step_dn)  dn_seen  <= dn_seen + 1;
      if (err_jump) err_seen <= err_seen + 1;
   end

   task automatic set_g(input int g);
      @(negedge clk);
      #1 gray_in = 4'(g);
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   int base;

   initial begin
      rst_n = 1'b0; clr = 1'b0; gray_in = 4'b0000;
      hold(3);
      #1 rst_n = 1'b1;

      // 1: baseline capture timing
      hold(S + 1);
      check("t1_valid_early", int'(valid), 0);
      hold(1);
      check("t1_valid_rise", int'(valid), 1);
      check("t1_bin", int'(bin_out), 0);
      check("t1_pulses", int'(step_up | step_dn | err_jump), 0);

      // 2: full upward sweep with wrap
      base = up_seen;
      for (int v = 0; v <= 16; v++) begin
         set_g(tb_b2g(v % 16));
         hold(3);
      end
      hold(4);
      check("t2_ups", up_seen - base, 16);
      check("t2_pos", int'($unsigned(position)), 16);
      check("t2_errc", int'(err_count), 0);
      check("t2_bin", int'(bin_out), 0);

      // 3: step down then an illegal jump
      for (int v = 1; v <= 5; v++) begin
         set_g(tb_b2g(v));
         hold(3);
      end
      hold(4);
      check("t3_bin5", int'(bin_out), 5);
      base = dn_seen;
      set_g(4'b0110);
      hold(4);
      check("t3_dn", dn_seen - base, 1);
      check("t3_bin4", int'(bin_out), 4);
      check("t3_pos_dn", int'($unsigned(position)), 20);
      base = err_seen;
      set_g(4'b0000);
      hold(4);
      check("t3_err", err_seen - base, 1);
      check("t3_errc", int'(err_count), 1);
      check("t3_pos_hold", int'($unsigned(position)), 20);
      check("t3_bin0", int'(bin_out), 0);

      // 4: error saturation
      for (int i = 0; i < 300; i++) begin
         set_g((i % 2 == 0) ? 4'b1100 : 4'b0000);
      end
      hold(4);
      check("t4_errc_sat", int'(err_count), 255);
      check("t4_pos", int'($unsigned(position)), 20);

      // 5: clr coinciding with a step
      set_g(4'b0001);
      hold(2);
      #1 clr = 1'b1;
      hold(1);
      check("t5_step_up", int'(step_up), 1);
      check("t5_pos_clr", int'($unsigned(position)), 0);
      check("t5_errc_clr", int'(err_count), 0);
      check("t5_bin", int'(bin_out), 1);
      #1 clr = 1'b0;

      // 6: reset mid-sweep, re-baseline at bin 6
      for (int v = 2; v <= 8; v++) begin
         set_g(tb_b2g(v));
         hold(3);
      end
      hold(4);
      check("t6_pos7", int'($unsigned(position)), 7);
      @(negedge clk);
      #3 rst_n = 1'b0;
      gray_in = 4'b0101;
      #1;
      check("t6_rst_valid", int'(valid), 0);
      check("t6_rst_bin", int'(bin_out), 0);
      check("t6_rst_pos", int'($unsigned(position)), 0);
      check("t6_rst_pulses", int'(step_up | step_dn | err_jump), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      hold(S + 1);
      check("t6_valid_early", int'(valid), 0);
      hold(1);
      check("t6_valid", int'(valid), 1);
      check("t6_bin6", int'(bin_out), 6);
      check("t6_pos0", int'($unsigned(position)), 0);
      check("t6_no_step", int'(step_up | step_dn | err_jump), 0);
      hold(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
